dbus_router: RTL and testbench

Data-bus router between the core's load/store port and its two slaves: data memory and the CLINT timer/interrupt block. Decodes each address, posts stores through a small write buffer so the core does not wait on slave acceptance, and serialises loads behind pending stores to preserve program order. Unmapped accesses are absorbed and flagged, never hang the bus.

---
 rtl/dbus_router_pkg.sv | 56 +++++
 rtl/dbus_router_if.sv | 32 +++
 rtl/dbus_wbuf.sv | 65 ++++++
 rtl/dbus_router.sv | 141 ++++++++++++++
 tb/tb_dbus_router.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dbus_router_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dbus_router_pkg
// Description : Address map defaults, target encoding, write-buffer entry
//               layout and the address decoder shared by the data-bus router.
// Revision    : 1.0 - initial release
// ============================================================================
package dbus_router_pkg;

  // Default address map
  localparam logic [31:0] MEM_SIZE_DEF   = 32'h0002_0000;
  localparam logic [31:0] CLINT_BASE_DEF = 32'h9000_0000;
  localparam logic [31:0] CLINT_MASK_DEF = 32'hffff_ffe0;

  // Slave target encoding
  typedef enum logic {
    TGT_MEM   = 1'b0,
    TGT_CLINT = 1'b1
  } tgt_e;

  // One posted store as held in the write buffer
  typedef struct packed {
    tgt_e        tgt;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wbuf_entry_t;

  localparam int WBUF_W = $bits(wbuf_entry_t);

  // Decoder result: mapped flag plus target when mapped
  typedef struct packed {
    logic mapped;
    tgt_e tgt;
  } dec_t;

  // Memory wins over CLINT when the two regions overlap
  function automatic dec_t addr_decode(input logic [31:0] addr,
                                       input logic [31:0] mem_size,
                                       input logic [31:0] clint_base,
                                       input logic [31:0] clint_mask);
    dec_t d;
    d.mapped = 1'b1;
    d.tgt    = TGT_MEM;
    if (addr < mem_size) begin
      d.tgt = TGT_MEM;
    end else if ((addr & clint_mask) == clint_base) begin
      d.tgt = TGT_CLINT;
    end else begin
      d.mapped = 1'b0;
    end
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dbus_router_if.sv
`default_nettype none
// ============================================================================
// Module      : dbus_router_if
// Description : Load/store bus bundle. The requester (core, or the router
//               towards a slave) uses the master modport; the responder uses
//               the slave modport.
// Revision    : 1.0 - initial release
// ============================================================================
interface dbus_router_if;
  logic        wready;   // store request
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;   // store accepted
  logic        rready;   // load request
  logic [31:0] raddr;
  logic        rvalid;   // load accepted
  logic        rresp;    // load data valid
  logic [31:0] rdata;
  logic        rerr;     // load error

  modport master (
    output wready, waddr, wdata, wstrb, rready, raddr,
    input  wvalid, rvalid, rresp, rdata, rerr
  );

  modport slave (
    input  wready, waddr, wdata, wstrb, rready, raddr,
    output wvalid, rvalid, rresp, rdata, rerr
  );
endinterface
`default_nettype wire

// File: rtl/dbus_wbuf.sv
`default_nettype none
// ============================================================================
// Module      : dbus_wbuf
// Description : Synchronous FIFO used as the store write buffer. Pointers
//               carry one extra wrap bit so full/empty need no counter.
// Revision    : 1.0 - initial release
// ============================================================================
module dbus_wbuf #(
  parameter int WIDTH = 69,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 0;
  localparam int IW = (AW > 0) ? AW : 1;
  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

  logic [AW:0]      wptr_q, rptr_q;
  logic [IW-1:0]    widx, ridx;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  // A single-entry buffer has no index bits; slot 0 is always used
  generate
    if (AW > 0) begin : g_idx_multi
      assign widx = wptr_q[IW-1:0];
      assign ridx = rptr_q[IW-1:0];
    end else begin : g_idx_single
      assign widx = '0;
      assign ridx = '0;
    end
  endgenerate

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = ((wptr_q - rptr_q) == DEPTH_CNT);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[ridx];

  // Advance read/write pointers; reset empties the buffer
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // Entry storage; contents are only meaningful between push and pop
  always_ff @(posedge clk) begin
    if (do_push) mem_q[widx] <= push_data_i;
  end

endmodule
`default_nettype wire

// File: rtl/dbus_router.sv
`default_nettype none
// ============================================================================
// Module      : dbus_router
// Description : Routes core loads/stores to data memory or CLINT. Stores are
//               posted through a write buffer; loads wait for the buffer to
//               drain so program order holds. Unmapped accesses are absorbed
//               and flagged.
// Revision    : 1.0 - initial release
// ============================================================================
module dbus_router
  import dbus_router_pkg::*;
#(
  parameter int          WBUF_DEPTH = 2,
  parameter logic [31:0] MEM_SIZE   = MEM_SIZE_DEF,
  parameter logic [31:0] CLINT_BASE = CLINT_BASE_DEF,
  parameter logic [31:0] CLINT_MASK = CLINT_MASK_DEF
) (
  input  logic         clk,
  input  logic         resetb,
  dbus_router_if.slave  core_bus,
  dbus_router_if.master mem_bus,
  dbus_router_if.master clint_bus,
  output logic         w_err_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ERR  = 2'd2;

  logic [1:0]  state_q, state_d;
  tgt_e        tgt_q, tgt_d;
  logic        w_err_q;

  dec_t        wdec, rdec;
  wbuf_entry_t push_entry, head;
  logic        full, empty, push, pop, st_acc;
  logic        ld_open, ld_mapped_stall;
  logic        req_rvalid, sel_rresp;
  logic [31:0] sel_rdata;
  logic        wait_resp;

  // ---------------- store path ----------------
  assign wdec       = addr_decode(core_bus.waddr, MEM_SIZE, CLINT_BASE, CLINT_MASK);
  assign st_acc     = core_bus.wready && !full;
  assign push       = st_acc && wdec.mapped;
  assign push_entry = '{tgt: wdec.tgt, addr: core_bus.waddr,
                        data: core_bus.wdata, strb: core_bus.wstrb};

  assign core_bus.wvalid = !full;

  dbus_wbuf #(
    .WIDTH (WBUF_W),
    .DEPTH (WBUF_DEPTH)
  ) u_wbuf (
    .clk         (clk),
    .resetb      (resetb),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .full_o      (full),
    .empty_o     (empty),
    .head_o      (head)
  );

  // Buffer head is offered only to its own target
  assign mem_bus.wready   = !empty && (head.tgt == TGT_MEM);
  assign clint_bus.wready = !empty && (head.tgt == TGT_CLINT);
  assign mem_bus.waddr    = mem_bus.wready   ? head.addr : '0;
  assign mem_bus.wdata    = mem_bus.wready   ? head.data : '0;
  assign mem_bus.wstrb    = mem_bus.wready   ? head.strb : '0;
  assign clint_bus.waddr  = clint_bus.wready ? head.addr : '0;
  assign clint_bus.wdata  = clint_bus.wready ? head.data : '0;
  assign clint_bus.wstrb  = clint_bus.wready ? head.strb : '0;
  assign pop = (mem_bus.wready && mem_bus.wvalid) ||
               (clint_bus.wready && clint_bus.wvalid);

  // Dropped unmapped store is reported the cycle after acceptance
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) w_err_q <= 1'b0;
    else         w_err_q <= st_acc && !wdec.mapped;
  end

  assign w_err_o = w_err_q;

  // ---------------- load path ----------------
  assign rdec = addr_decode(core_bus.raddr, MEM_SIZE, CLINT_BASE, CLINT_MASK);

  // Loads open only when idle, the buffer is drained and no store wins this cycle
  assign ld_open    = (state_q == ST_IDLE) && empty && !st_acc;
  assign req_rvalid = (rdec.tgt == TGT_CLINT) ? clint_bus.rvalid : mem_bus.rvalid;
  assign ld_mapped_stall = core_bus.rready && rdec.mapped && !req_rvalid;

  assign mem_bus.rready   = ld_open && core_bus.rready && rdec.mapped && (rdec.tgt == TGT_MEM);
  assign clint_bus.rready = ld_open && core_bus.rready && rdec.mapped && (rdec.tgt == TGT_CLINT);
  assign mem_bus.raddr    = mem_bus.rready   ? core_bus.raddr : '0;
  assign clint_bus.raddr  = clint_bus.rready ? core_bus.raddr : '0;

  assign core_bus.rvalid = ld_open && !ld_mapped_stall;

  assign sel_rresp = (tgt_q == TGT_CLINT) ? clint_bus.rresp : mem_bus.rresp;
  assign sel_rdata = (tgt_q == TGT_CLINT) ? clint_bus.rdata : mem_bus.rdata;
  assign wait_resp = (state_q == ST_WAIT) && sel_rresp;

  assign core_bus.rresp = wait_resp || (state_q == ST_ERR);
  assign core_bus.rerr  = (state_q == ST_ERR);
  assign core_bus.rdata = wait_resp ? sel_rdata : '0;

  // Load FSM next-state: accept, wait for the slave's response, or report error
  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    case (state_q)
      ST_IDLE: begin
        if (ld_open && core_bus.rready) begin
          if (!rdec.mapped) begin
            state_d = ST_ERR;
          end else if (req_rvalid) begin
            state_d = ST_WAIT;
            tgt_d   = rdec.tgt;
          end
        end
      end
      ST_WAIT: if (sel_rresp) state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Load FSM state and latched target register
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q <= ST_IDLE;
      tgt_q   <= TGT_MEM;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dbus_router.sv
`default_nettype none
// ============================================================================
// Module      : tb_dbus_router
// Description : Directed self-checking bench for dbus_router with simple
//               memory and CLINT slave models.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dbus_router;
  logic clk;
  logic resetb;
  logic w_err;

  dbus_router_if core_bus ();
  dbus_router_if mem_bus ();
  dbus_router_if clint_bus ();

  dbus_router #(
    .WBUF_DEPTH (2),
    .MEM_SIZE   (32'h0002_0000),
    .CLINT_BASE (32'h9000_0000),
    .CLINT_MASK (32'hffff_ffe0)
  ) dut (
    .clk       (clk),
    .resetb    (resetb),
    .core_bus  (core_bus),
    .mem_bus   (mem_bus),
    .clint_bus (clint_bus),
    .w_err_o   (w_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- memory slave model ----------------
  logic        mem_wvalid, mem_rvalid, mem_rresp_en;
  logic        mem_pend;
  logic [31:0] mem_paddr;
  logic [31:0] mem_log_addr [$];
  logic [31:0] mem_log_data [$];
  int          rd_cnt = 0;
  int          clint_wcnt = 0;

  assign mem_bus.wvalid = mem_wvalid;
  assign mem_bus.rvalid = mem_rvalid;
  assign mem_bus.rresp  = mem_pend && mem_rresp_en;
  assign mem_bus.rdata  = mem_bus.rresp ? ~mem_paddr : 32'h0;
  assign mem_bus.rerr   = 1'b0;

  always @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      mem_pend  <= 1'b0;
      mem_paddr <= 32'h0;
    end else begin
      if (mem_bus.wready && mem_bus.wvalid) begin
        mem_log_addr.push_back(mem_bus.waddr);
        mem_log_data.push_back(mem_bus.wdata);
      end
      if (mem_bus.rready && mem_bus.rvalid) begin
        mem_pend  <= 1'b1;
        mem_paddr <= mem_bus.raddr;
      end else if (mem_bus.rresp) begin
        mem_pend <= 1'b0;
      end
    end
  end

  // ---------------- CLINT slave model ----------------
  logic        clint_rresp;
  logic [31:0] clint_rdata;
  logic [31:0] clint_regs [8];

  assign clint_bus.wvalid = 1'b1;
  assign clint_bus.rvalid = 1'b1;
  assign clint_bus.rresp  = clint_rresp;
  assign clint_bus.rdata  = clint_rdata;
  assign clint_bus.rerr   = 1'b0;

  always @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      clint_rresp <= 1'b0;
      clint_rdata <= 32'h0;
      for (int i = 0; i < 8; i++) clint_regs[i] <= 32'h0;
    end else begin
      if (clint_bus.wready && clint_bus.wvalid) begin
        for (int b = 0; b < 4; b++)
          if (clint_bus.wstrb[b])
            clint_regs[clint_bus.waddr[4:2]][8*b +: 8] <= clint_bus.wdata[8*b +: 8];
      end
      clint_rresp <= clint_bus.rready && clint_bus.rvalid;
      clint_rdata <= (clint_bus.rready && clint_bus.rvalid) ? clint_regs[clint_bus.raddr[4:2]] : 32'h0;
    end
  end

  // Observation counters for slave strobes
  always @(posedge clk) begin
    if (clint_bus.wready && clint_bus.wvalid) clint_wcnt <= clint_wcnt + 1;
    if ((mem_bus.rready && mem_bus.rvalid) || (clint_bus.rready && clint_bus.rvalid)) rd_cnt <= rd_cnt + 1;
  end

  // ---------------- helpers ----------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_core();
    core_bus.wready = 1'b0;
    core_bus.waddr  = 32'h0;
    core_bus.wdata  = 32'h0;
    core_bus.wstrb  = 4'h0;
    core_bus.rready = 1'b0;
    core_bus.raddr  = 32'h0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    core_bus.wready = 1'b1;
    core_bus.waddr  = a;
    core_bus.wdata  = d;
    core_bus.wstrb  = 4'hf;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    resetb = 1'b0;
    idle_core();
    mem_wvalid = 1'b0; mem_rvalid = 1'b1; mem_rresp_en = 1'b1;
    step(); step(); #1;
    checks++; if (core_bus.rresp !== 1'b0) begin errors++; $display("FAIL rst_rresp: got %b exp 0", core_bus.rresp); end
    checks++; if (core_bus.rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h exp 0", core_bus.rdata); end
    checks++; if (core_bus.rerr !== 1'b0) begin errors++; $display("FAIL rst_rerr: got %b exp 0", core_bus.rerr); end
    checks++; if (w_err !== 1'b0) begin errors++; $display("FAIL rst_werr: got %b exp 0", w_err); end
    checks++; if ({mem_bus.wready, mem_bus.rready, clint_bus.wready, clint_bus.rready} !== 4'b0)
      begin errors++; $display("FAIL rst_slave_strobes: got %b exp 0000",
        {mem_bus.wready, mem_bus.rready, clint_bus.wready, clint_bus.rready}); end
    resetb = 1'b1;
    step(); #1;
    checks++; if (core_bus.wvalid !== 1'b1) begin errors++; $display("FAIL rst_wvalid: got %b exp 1", core_bus.wvalid); end
    checks++; if (core_bus.rvalid !== 1'b1) begin errors++; $display("FAIL rst_rvalid: got %b exp 1", core_bus.rvalid); end
  endtask

  task automatic test_clint_store();
    step(); store(32'h9000_0008, 32'h1234_5678); #1;
    checks++; if (core_bus.wvalid !== 1'b1) begin errors++; $display("FAIL cst_accept: got %b exp 1", core_bus.wvalid); end
    checks++; if (clint_bus.wready !== 1'b0) begin errors++; $display("FAIL cst_early: got %b exp 0", clint_bus.wready); end
    step(); idle_core(); #1;
    checks++; if (clint_bus.wready !== 1'b1) begin errors++; $display("FAIL cst_present: got %b exp 1", clint_bus.wready); end
    checks++; if (clint_bus.waddr !== 32'h9000_0008) begin errors++; $display("FAIL cst_addr: got %h exp 90000008", clint_bus.waddr); end
    checks++; if (clint_bus.wdata !== 32'h1234_5678) begin errors++; $display("FAIL cst_data: got %h exp 12345678", clint_bus.wdata); end
    checks++; if (mem_bus.wready !== 1'b0) begin errors++; $display("FAIL cst_mem_quiet: got %b exp 0", mem_bus.wready); end
    step(); #1;
    checks++; if (clint_bus.wready !== 1'b0) begin errors++; $display("FAIL cst_drained: got %b exp 0", clint_bus.wready); end
    checks++; if (core_bus.rvalid !== 1'b1) begin errors++; $display("FAIL cst_empty_rvalid: got %b exp 1", core_bus.rvalid); end
    checks++; if (clint_regs[2] !== 32'h1234_5678) begin errors++; $display("FAIL cst_written: got %h exp 12345678", clint_regs[2]); end
  endtask

  task automatic test_wbuf_full();
    logic [31:0] exp_a [3];
    logic [31:0] exp_d [3];
    exp_a[0] = 32'h100; exp_a[1] = 32'h104; exp_a[2] = 32'h108;
    exp_d[0] = 32'hA1;  exp_d[1] = 32'hA2;  exp_d[2] = 32'hA3;
    mem_log_addr.delete(); mem_log_data.delete();
    step(); mem_wvalid = 1'b0; store(32'h100, 32'hA1); #1;
    checks++; if (core_bus.wvalid !== 1'b1) begin errors++; $display("FAIL full_acc1: got %b exp 1", core_bus.wvalid); end
    step(); store(32'h104, 32'hA2); #1;
    checks++; if (core_bus.wvalid !== 1'b1) begin errors++; $display("FAIL full_acc2: got %b exp 1", core_bus.wvalid); end
    checks++; if (mem_bus.waddr !== 32'h100) begin errors++; $display("FAIL full_head1: got %h exp 100", mem_bus.waddr); end
    step(); store(32'h108, 32'hA3); #1;
    checks++; if (core_bus.wvalid !== 1'b0) begin errors++; $display("FAIL full_block: got %b exp 0", core_bus.wvalid); end
    step(); mem_wvalid = 1'b1; #1;
    checks++; if (core_bus.wvalid !== 1'b0) begin errors++; $display("FAIL full_pop_same_cycle: got %b exp 0", core_bus.wvalid); end
    step(); mem_wvalid = 1'b0; #1;
    checks++; if (core_bus.wvalid !== 1'b1) begin errors++; $display("FAIL full_freed: got %b exp 1", core_bus.wvalid); end
    checks++; if (mem_bus.waddr !== 32'h104) begin errors++; $display("FAIL full_head2: got %h exp 104", mem_bus.waddr); end
    step(); idle_core(); mem_wvalid = 1'b1;
    step();
    step(); mem_wvalid = 1'b0; #1;
    checks++; if (mem_bus.wready !== 1'b0) begin errors++; $display("FAIL full_drained: got %b exp 0", mem_bus.wready); end
    checks++; if (mem_log_addr.size() !== 3) begin errors++; $display("FAIL full_count: got %0d exp 3", mem_log_addr.size()); end
    for (int i = 0; i < 3; i++) begin
      if (i < mem_log_addr.size()) begin
        checks++; if (mem_log_addr[i] !== exp_a[i] || mem_log_data[i] !== exp_d[i]) begin errors++;
          $display("FAIL full_order%0d: got %h/%h exp %h/%h", i, mem_log_addr[i], mem_log_data[i], exp_a[i], exp_d[i]); end
      end
    end
  endtask

  task automatic test_store_then_load();
    step(); store(32'h9000_0000, 32'hCAFE_F00D); #1;
    checks++; if (core_bus.wvalid !== 1'b1) begin errors++; $display("FAIL sl_store: got %b exp 1", core_bus.wvalid); end
    step(); idle_core(); core_bus.rready = 1'b1; core_bus.raddr = 32'h9000_0000; #1;
    checks++; if (core_bus.rvalid !== 1'b0) begin errors++; $display("FAIL sl_held: got %b exp 0", core_bus.rvalid); end
    checks++; if (clint_bus.rready !== 1'b0) begin errors++; $display("FAIL sl_no_issue: got %b exp 0", clint_bus.rready); end
    step(); #1;
    checks++; if (core_bus.rvalid !== 1'b1) begin errors++; $display("FAIL sl_accept: got %b exp 1", core_bus.rvalid); end
    checks++; if (clint_bus.rready !== 1'b1 || clint_bus.raddr !== 32'h9000_0000) begin errors++;
      $display("FAIL sl_issue: got %b/%h exp 1/90000000", clint_bus.rready, clint_bus.raddr); end
    step(); idle_core(); #1;
    checks++; if (core_bus.rresp !== 1'b1) begin errors++; $display("FAIL sl_resp: got %b exp 1", core_bus.rresp); end
    checks++; if (core_bus.rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL sl_data: got %h exp cafef00d", core_bus.rdata); end
    step(); #1;
    checks++; if (core_bus.rresp !== 1'b0 || core_bus.rdata !== 32'h0) begin errors++;
      $display("FAIL sl_resp_end: got %b/%h exp 0/0", core_bus.rresp, core_bus.rdata); end
  endtask

  task automatic test_back_to_back();
    step(); core_bus.rready = 1'b1; core_bus.raddr = 32'h9000_0008; #1;
    checks++; if (core_bus.rvalid !== 1'b1) begin errors++; $display("FAIL b2b_acc1: got %b exp 1", core_bus.rvalid); end
    step(); core_bus.raddr = 32'h9000_0000; #1;
    checks++; if (core_bus.rvalid !== 1'b0) begin errors++; $display("FAIL b2b_wait: got %b exp 0", core_bus.rvalid); end
    checks++; if (core_bus.rdata !== 32'h1234_5678) begin errors++; $display("FAIL b2b_data1: got %h exp 12345678", core_bus.rdata); end
    step(); #1;
    checks++; if (core_bus.rvalid !== 1'b1) begin errors++; $display("FAIL b2b_acc2: got %b exp 1", core_bus.rvalid); end
    step(); idle_core(); #1;
    checks++; if (core_bus.rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL b2b_data2: got %h exp cafef00d", core_bus.rdata); end
  endtask

  task automatic test_unmapped();
    int wc, mc, rc;
    wc = clint_wcnt; mc = mem_log_addr.size(); rc = rd_cnt;
    step(); core_bus.rready = 1'b1; core_bus.raddr = 32'h4000_0000; #1;
    checks++; if (core_bus.rvalid !== 1'b1) begin errors++; $display("FAIL um_ld_acc: got %b exp 1", core_bus.rvalid); end
    step(); idle_core(); #1;
    checks++; if ({core_bus.rresp, core_bus.rerr} !== 2'b11 || core_bus.rdata !== 32'h0) begin errors++;
      $display("FAIL um_ld_err: got %b%b/%h exp 11/0", core_bus.rresp, core_bus.rerr, core_bus.rdata); end
    step(); store(32'h4000_0000, 32'hDEAD_BEEF); #1;
    checks++; if ({core_bus.rresp, core_bus.rerr} !== 2'b00) begin errors++; $display("FAIL um_ld_end: got %b%b exp 00", core_bus.rresp, core_bus.rerr); end
    checks++; if (core_bus.wvalid !== 1'b1 || w_err !== 1'b0) begin errors++; $display("FAIL um_st_acc: got %b/%b exp 1/0", core_bus.wvalid, w_err); end
    step(); idle_core(); #1;
    checks++; if (w_err !== 1'b1) begin errors++; $display("FAIL um_werr: got %b exp 1", w_err); end
    checks++; if (mem_bus.wready !== 1'b0 || clint_bus.wready !== 1'b0) begin errors++;
      $display("FAIL um_no_issue: got %b/%b exp 0/0", mem_bus.wready, clint_bus.wready); end
    step(); #1;
    checks++; if (w_err !== 1'b0) begin errors++; $display("FAIL um_werr_pulse: got %b exp 0", w_err); end
    checks++; if (clint_wcnt !== wc || mem_log_addr.size() !== mc || rd_cnt !== rc) begin errors++;
      $display("FAIL um_slave_activity: got %0d/%0d/%0d exp %0d/%0d/%0d", clint_wcnt, mem_log_addr.size(), rd_cnt, wc, mc, rc); end
  endtask

  task automatic test_collision_mem_load();
    step(); mem_wvalid = 1'b1; store(32'h200, 32'h55);
    core_bus.rready = 1'b1; core_bus.raddr = 32'h9000_0004; #1;
    checks++; if (core_bus.wvalid !== 1'b1) begin errors++; $display("FAIL col_store: got %b exp 1", core_bus.wvalid); end
    checks++; if (core_bus.rvalid !== 1'b0 || clint_bus.rready !== 1'b0) begin errors++;
      $display("FAIL col_load_blocked: got %b/%b exp 0/0", core_bus.rvalid, clint_bus.rready); end
    step(); idle_core(); #1;
    checks++; if (mem_bus.wready !== 1'b1 || mem_bus.waddr !== 32'h200) begin errors++;
      $display("FAIL col_mem_store: got %b/%h exp 1/200", mem_bus.wready, mem_bus.waddr); end
    step(); mem_wvalid = 1'b0; mem_rvalid = 1'b0; core_bus.rready = 1'b1; core_bus.raddr = 32'h10; #1;
    checks++; if (core_bus.rvalid !== 1'b0) begin errors++; $display("FAIL ml_retry: got %b exp 0", core_bus.rvalid); end
    checks++; if (mem_bus.rready !== 1'b1 || mem_bus.raddr !== 32'h10) begin errors++;
      $display("FAIL ml_issue: got %b/%h exp 1/10", mem_bus.rready, mem_bus.raddr); end
    step(); mem_rvalid = 1'b1; #1;
    checks++; if (core_bus.rvalid !== 1'b1) begin errors++; $display("FAIL ml_accept: got %b exp 1", core_bus.rvalid); end
    step(); idle_core(); #1;
    checks++; if (core_bus.rresp !== 1'b1 || core_bus.rdata !== 32'hFFFF_FFEF) begin errors++;
      $display("FAIL ml_data: got %b/%h exp 1/ffffffef", core_bus.rresp, core_bus.rdata); end
  endtask

  task automatic test_reset_midflight();
    int mc, rc;
    step(); mem_rresp_en = 1'b0; mem_wvalid = 1'b0; core_bus.rready = 1'b1; core_bus.raddr = 32'h20; #1;
    checks++; if (core_bus.rvalid !== 1'b1) begin errors++; $display("FAIL rm_load: got %b exp 1", core_bus.rvalid); end
    step(); idle_core(); store(32'h300, 32'h11); #1;
    checks++; if (core_bus.wvalid !== 1'b1 || core_bus.rvalid !== 1'b0 || core_bus.rresp !== 1'b0) begin errors++;
      $display("FAIL rm_wait_store1: got %b/%b/%b exp 1/0/0", core_bus.wvalid, core_bus.rvalid, core_bus.rresp); end
    step(); store(32'h304, 32'h22); #1;
    checks++; if (core_bus.wvalid !== 1'b1) begin errors++; $display("FAIL rm_store2: got %b exp 1", core_bus.wvalid); end
    step(); idle_core(); #1;
    checks++; if (mem_bus.wready !== 1'b1) begin errors++; $display("FAIL rm_buffered: got %b exp 1", mem_bus.wready); end
    resetb = 1'b0; #1;
    checks++; if ({core_bus.rresp, core_bus.rerr, w_err, mem_bus.wready, mem_bus.rready, clint_bus.wready, clint_bus.rready} !== 7'b0
                  || core_bus.rdata !== 32'h0) begin errors++;
      $display("FAIL rm_rst_outputs: got %b/%h exp 0/0", {core_bus.rresp, core_bus.rerr, w_err, mem_bus.wready,
               mem_bus.rready, clint_bus.wready, clint_bus.rready}, core_bus.rdata); end
    checks++; if (core_bus.wvalid !== 1'b1 || core_bus.rvalid !== 1'b1) begin errors++;
      $display("FAIL rm_rst_valids: got %b/%b exp 1/1", core_bus.wvalid, core_bus.rvalid); end
    step(); step(); resetb = 1'b1;
    mc = mem_log_addr.size(); rc = rd_cnt;
    mem_wvalid = 1'b1; mem_rresp_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); #1;
      checks++; if (core_bus.rresp !== 1'b0 || mem_bus.wready !== 1'b0) begin errors++;
        $display("FAIL rm_post_quiet%0d: got %b/%b exp 0/0", i, core_bus.rresp, mem_bus.wready); end
    end
    checks++; if (mem_log_addr.size() !== mc || rd_cnt !== rc) begin errors++;
      $display("FAIL rm_no_strobes: got %0d/%0d exp %0d/%0d", mem_log_addr.size(), rd_cnt, mc, rc); end
    mem_wvalid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_clint_store();
    test_wbuf_full();
    test_store_then_load();
    test_back_to_back();
    test_unmapped();
    test_collision_mem_load();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
